// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: word layout, FSM state codes, idle word.
package instr_sequencer_pkg;

  localparam int WORD_W  = 12;
  localparam int INSTR_W = 4;
  localparam int DATA_W  = 8;

  localparam logic [WORD_W-1:0] IDLE_WORD_DEF = 12'h000;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic [WORD_W-1:0] mkWord(input logic [INSTR_W-1:0] instr,
                                               input logic [DATA_W-1:0] data);
    return {instr, data};
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-load, run-control and core-feed signals of the sequencer.
// SINGLE_STEP_EN adds StepMode/Step.
interface instr_sequencer_if #(parameter int AW = 4);
  import instr_sequencer_pkg::*;

  logic              WrEn;
  logic [AW-1:0]     WrAddr;
  logic [WORD_W-1:0] WrData;
  logic [AW:0]       ProgLen;
  logic [3:0]        Loops;
  logic              Start;
  logic              Abort;
  logic [WORD_W-1:0] Out;
  logic              OutValid;
  logic [AW-1:0]     Pc;
  logic              Busy;
  logic              Done;
  logic              WrErr;
`ifdef SINGLE_STEP_EN
  logic              StepMode;
  logic              Step;
`endif

  modport master (
    output WrEn, WrAddr, WrData, ProgLen, Loops, Start, Abort,
`ifdef SINGLE_STEP_EN
    output StepMode, Step,
`endif
    input  Out, OutValid, Pc, Busy, Done, WrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, ProgLen, Loops, Start, Abort,
`ifdef SINGLE_STEP_EN
    input  StepMode, Step,
`endif
    output Out, OutValid, Pc, Busy, Done, WrErr
  );

endinterface

// File: rtl/instr_sequencer_prog_ram.sv
// Program RAM: DEPTH x 12, one synchronous write port, one asynchronous read port.
module prog_ram
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Streams program RAM words into the 12-bit core In bus with looping, abort and status.
// Optional SINGLE_STEP_EN gates issue on Step while StepMode is set.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                AW        = $clog2(DEPTH),
  parameter logic [WORD_W-1:0] IDLE_WORD = IDLE_WORD_DEF
) (
  input logic               i_clk,
  input logic               i_clr,
  instr_sequencer_if.slave  bus
);

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  logic [0:0]        r_state;
  logic [AW-1:0]     r_pc;
  logic [AW:0]       r_len;
  logic [3:0]        r_passes;
  logic [WORD_W-1:0] r_out;
  logic              r_outValid;
  logic              r_done;
  logic              r_wrErr;

  logic              w_we;
  logic              w_stepOk;
  logic              w_last;
  logic [WORD_W-1:0] w_rdata;
  logic [AW:0]       w_lenClamp;

  assign w_we       = bus.WrEn && (r_state == S_IDLE);
  assign w_last     = ({1'b0, r_pc} == (r_len - 1'b1));
  assign w_lenClamp = (bus.ProgLen > LEN_MAX) ? LEN_MAX : bus.ProgLen;
`ifdef SINGLE_STEP_EN
  assign w_stepOk   = !bus.StepMode || bus.Step;
`else
  assign w_stepOk   = 1'b1;
`endif

  prog_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (bus.WrAddr),
    .i_wdata (bus.WrData),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  // Out/OutValid/Done default to idle each cycle; only an issued word or a completion overrides them.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_len      <= '0;
      r_passes   <= '0;
      r_out      <= IDLE_WORD;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
      r_wrErr    <= 1'b0;
    end else begin
      r_out      <= IDLE_WORD;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
      r_wrErr    <= bus.WrEn && (r_state == S_RUN);
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            if (bus.ProgLen != '0) begin
              r_state  <= S_RUN;
              r_pc     <= '0;
              r_len    <= w_lenClamp;
              r_passes <= bus.Loops;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.Abort) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_done  <= 1'b1;
          end else if (w_stepOk) begin
            r_out      <= w_rdata;
            r_outValid <= 1'b1;
            if (w_last) begin
              r_pc <= '0;
              if (r_passes != 4'd0) begin
                r_passes <= r_passes - 4'd1;
              end else begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end
            end else begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.Out      = r_out;
  assign bus.OutValid = r_outValid;
  assign bus.Pc       = r_pc;
  assign bus.Busy     = (r_state == S_RUN);
  assign bus.Done     = r_done;
  assign bus.WrErr    = r_wrErr;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: queue-based stream model plus directed literal checks.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if #(.AW(AW)) bus();

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .IDLE_WORD(12'h000)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [11:0] memM [DEPTH];
  int          streamQ[$];
  logic [11:0] expOut   = 12'h000;
  logic        expValid = 1'b0;
  logic        expDone  = 1'b0;
  logic        expWrErr = 1'b0;
  bit          checking = 1'b0;

  logic [11:0] seen[$];
  int          doneCnt = 0;
  int          errCnt  = 0;

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is the list of addresses it will issue; each issuing edge pops one.
  always @(posedge clk) begin
    bit stepOk;
    stepOk = 1'b1;
`ifdef SINGLE_STEP_EN
    stepOk = !bus.StepMode || bus.Step;
`endif
    if (clr) begin
      streamQ.delete();
      expOut = 12'h000; expValid = 1'b0; expDone = 1'b0; expWrErr = 1'b0;
    end else begin
      expWrErr = bus.WrEn && (streamQ.size() != 0);
      expOut = 12'h000; expValid = 1'b0; expDone = 1'b0;
      if (streamQ.size() != 0) begin
        if (bus.Abort) begin
          streamQ.delete();
          expDone = 1'b1;
        end else if (stepOk) begin
          expOut   = memM[streamQ.pop_front()];
          expValid = 1'b1;
          expDone  = (streamQ.size() == 0);
        end
      end else begin
        if (bus.WrEn) memM[bus.WrAddr] = bus.WrData;
        if (bus.Start) begin
          int len;
          len = (int'(bus.ProgLen) > DEPTH) ? DEPTH : int'(bus.ProgLen);
          if (len == 0) expDone = 1'b1;
          for (int p = 0; p <= int'(bus.Loops); p++)
            for (int k = 0; k < len; k++) streamQ.push_back(k);
        end
      end
    end
    checking = 1'b1;
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("Out",      bus.Out,             expOut);
      checkOutput("OutValid", 12'(bus.OutValid),   12'(expValid));
      checkOutput("Done",     12'(bus.Done),       12'(expDone));
      checkOutput("WrErr",    12'(bus.WrErr),      12'(expWrErr));
      checkOutput("Busy",     12'(bus.Busy),       12'(streamQ.size() != 0));
      checkOutput("Pc",       12'(bus.Pc),         (streamQ.size() != 0) ? 12'(streamQ[0]) : 12'h000);
      if (bus.OutValid === 1'b1) seen.push_back(bus.Out);
      if (bus.Done === 1'b1) doneCnt++;
      if (bus.WrErr === 1'b1) errCnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [11:0] data);
    bus.WrEn = 1'b1; bus.WrAddr = addr; bus.WrData = data;
    @(negedge clk);
    bus.WrEn = 1'b0;
  endtask

  task automatic startRun(input int len, input int loops);
    bus.ProgLen = (AW+1)'(len); bus.Loops = 4'(loops); bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic clearLog();
    seen.delete(); doneCnt = 0; errCnt = 0;
  endtask

  task automatic checkSeen(input string name, input int idx, input logic [11:0] exp);
    logic [11:0] act;
    act = (idx < seen.size()) ? seen[idx] : 12'hxxx;
    checkOutput(name, act, exp);
  endtask

  initial begin
    bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0; bus.ProgLen = '0;
    bus.Loops = '0; bus.Start = 1'b0; bus.Abort = 1'b0;
`ifdef SINGLE_STEP_EN
    bus.StepMode = 1'b0; bus.Step = 1'b0;
`endif
    clr = 1'b1;
    idle(2);
    checkOutput("rstOut",  bus.Out, 12'h000);
    checkOutput("rstBusy", 12'(bus.Busy), 12'h0);
    clr = 1'b0;

    applyStimulus(4'd0, mkWord(4'h1, 8'hA5));
    applyStimulus(4'd1, 12'h2B6);
    applyStimulus(4'd2, 12'h3C7);
    applyStimulus(4'd3, 12'h4D8);
    for (int i = 4; i < DEPTH; i++) applyStimulus(AW'(i), 12'h500 + 12'(i));

    $display("[TB] single pass of 4 words");
    clearLog();
    startRun(4, 0);
    idle(6);
    checkOutput("t1Count", 12'(seen.size()), 12'd4);
    checkSeen("t1W0", 0, 12'h1A5);
    checkSeen("t1W1", 1, 12'h2B6);
    checkSeen("t1W2", 2, 12'h3C7);
    checkSeen("t1W3", 3, 12'h4D8);
    checkOutput("t1Done", 12'(doneCnt), 12'd1);

    $display("[TB] 2 words x 3 passes");
    clearLog();
    startRun(2, 2);
    idle(8);
    checkOutput("t2Count", 12'(seen.size()), 12'd6);
    for (int i = 0; i < 6; i++) checkSeen("t2W", i, (i % 2 == 0) ? 12'h1A5 : 12'h2B6);
    checkOutput("t2Done", 12'(doneCnt), 12'd1);

    $display("[TB] abort on third run cycle");
    clearLog();
    startRun(4, 0);
    idle(2);
    bus.Abort = 1'b1;
    @(negedge clk);
    bus.Abort = 1'b0;
    checkOutput("t3Pc",    12'(bus.Pc), 12'h0);
    checkOutput("t3Valid", 12'(bus.OutValid), 12'h0);
    checkOutput("t3DoneP", 12'(bus.Done), 12'h1);
    idle(3);
    checkOutput("t3Count", 12'(seen.size()), 12'd2);
    checkOutput("t3Done",  12'(doneCnt), 12'd1);

    $display("[TB] write during run and zero-length start");
    clearLog();
    startRun(4, 0);
    bus.WrEn = 1'b1; bus.WrAddr = '0; bus.WrData = 12'hFFF;
    @(negedge clk);
    bus.WrEn = 1'b0;
    idle(5);
    checkOutput("t4WrErr", 12'(errCnt), 12'd1);
    clearLog();
    startRun(1, 0);
    idle(3);
    checkOutput("t4Count", 12'(seen.size()), 12'd1);
    checkSeen("t4Mem0", 0, 12'h1A5);
    clearLog();
    startRun(0, 0);
    idle(3);
    checkOutput("t4ZeroDone",  12'(doneCnt), 12'd1);
    checkOutput("t4ZeroCount", 12'(seen.size()), 12'd0);

    $display("[TB] clear mid-run and length clamp");
    clearLog();
    startRun(4, 0);
    idle(1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("t5Out",  bus.Out, 12'h000);
    checkOutput("t5Busy", 12'(bus.Busy), 12'h0);
    checkOutput("t5Pc",   12'(bus.Pc), 12'h0);
    idle(3);
    checkOutput("t5Done",  12'(doneCnt), 12'd0);
    checkOutput("t5Count", 12'(seen.size()), 12'd1);
    clearLog();
    startRun(17, 0);
    idle(18);
    checkOutput("t5ClampCount", 12'(seen.size()), 12'd16);
    checkSeen("t5Last", 15, 12'h50F);
    checkOutput("t5ClampDone", 12'(doneCnt), 12'd1);

`ifdef SINGLE_STEP_EN
    $display("[TB] single step every third cycle");
    clearLog();
    bus.StepMode = 1'b1;
    startRun(4, 0);
    for (int i = 0; i < 15; i++) begin
      bus.Step = (i % 3 == 2);
      @(negedge clk);
    end
    bus.Step = 1'b0;
    bus.StepMode = 1'b0;
    idle(2);
    checkOutput("t6Count", 12'(seen.size()), 12'd4);
    checkSeen("t6W3", 3, 12'h4D8);
    checkOutput("t6Done", 12'(doneCnt), 12'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
